aes_round_sched: RTL

Iterative round scheduler for the AES-128/192/256 cipher path. Accepts one block plus key on a valid/ready handshake and latches them. It then sequences a shared, external single-round unit and round-key store over the initial AddRoundKey and Nr rounds, in encrypt or decrypt order. The finished block is presented on a valid/ready output. It replaces the fully unrolled combinational Encrypt/Decrypt instances where area matters, and is the only state-holding element between the round unit and the host interface.

---
 rtl/aes_round_sched.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/aes_round_sched.sv
// aes_round_sched
// ----------------------------------------------------------------------------
// Iterative AES-128/192/256 round scheduler. It accepts one block, key and
// mode and latches them. It then drives an external single-round unit and
// round-key store: first the initial AddRoundKey, then Nr rounds, in either
// encrypt order (keys 0..Nr) or decrypt order (keys Nr..0). The finished block
// is then presented on the output handshake.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where valid
// and ready are both high. in_ready is high only in IDLE. out_valid stays high,
// with out_data stable, until out_ready is sampled high. Neither valid depends
// combinationally on the matching ready.
//
// Ports (vectors use [0:N-1], bit 0 = MSB):
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready input handshake; in_mode 0=encrypt 1=decrypt
//   in_data, in_key   block and cipher key, sampled only on accept
//   key_out           latched key for the round-key store
//   rk_idx, rk_in     round-key index requested / key returned (zero latency)
//   rnd_state         current state to the round unit
//   rnd_mode          latched mode
//   rnd_last          final round (round unit skips (Inv)MixColumns)
//   rnd_result        round-unit output for the current state and key
//   out_valid/out_ready/out_data  result handshake
//   busy              high in every state other than IDLE
//   dbg_state         encoded FSM state (IDLE=0, KEY0=1, ROUND=2, DONE=3)
// ----------------------------------------------------------------------------
module aes_round_sched #(
  parameter int Nb = 4,
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [0:Nb*32-1]  in_data,
  input  logic [0:Nk*32-1]  in_key,
  output logic [0:Nk*32-1]  key_out,
  output logic [3:0]        rk_idx,
  input  logic [0:Nb*32-1]  rk_in,
  output logic [0:Nb*32-1]  rnd_state,
  output logic              rnd_mode,
  output logic              rnd_last,
  input  logic [0:Nb*32-1]  rnd_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:Nb*32-1]  out_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic [3:0] NR4 = 4'(Nr);

  fsm_t               fsm_q;
  fsm_t               fsm_d;
  logic [0:Nb*32-1]   state_q;
  logic [0:Nk*32-1]   key_q;
  logic [3:0]         round_q;
  logic               mode_q;

  assign rnd_state = state_q;
  assign key_out   = key_q;
  assign rnd_mode  = mode_q;
  assign dbg_state = fsm_q;

  // Next state and the three decoded outputs. Everything here depends only on
  // registered state, except fsm_d, which also looks at the handshake inputs.
  always_comb begin
    fsm_d    = fsm_q;
    in_ready = 1'b0;
    rk_idx   = 4'd0;
    rnd_last = 1'b0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) fsm_d = KEY0;
      end
      KEY0: begin
        rk_idx = mode_q ? NR4 : 4'd0;
        fsm_d  = ROUND;
      end
      ROUND: begin
        // Decrypt walks the key schedule backwards.
        rk_idx   = mode_q ? (NR4 - round_q) : round_q;
        rnd_last = (round_q == NR4);
        if (round_q == NR4) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      key_q     <= '0;
      round_q   <= 4'd0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      busy      <= (fsm_d != IDLE);
      out_valid <= (fsm_d == DONE);
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= in_data;
            key_q   <= in_key;
            mode_q  <= in_mode;
            round_q <= 4'd0;
          end
        end
        KEY0: begin
          state_q <= state_q ^ rk_in;
          round_q <= 4'd1;
        end
        ROUND: begin
          state_q <= rnd_result;
          // The counter stops at Nr; the final result is also copied to the
          // output register so it stays frozen while DONE waits on out_ready.
          if (round_q == NR4) begin
            out_data <= rnd_result;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
